// File: rtl/systolic_tile_sequencer.sv
// Command sequencer for the systolic array: walks a multi-tile matmul command through
// reader/writer requests, array start and writer drain, then reports a status response.
//
// state | meaning
// ------+----------------------------------------------------
// IDLE  | ready to accept a command
// ISSUE | act/wgt/out requests for tile t outstanding
// START | requesting the array to start tile t
// RUN   | array computing tile t
// DRAIN | last tile done, waiting for writer to commit
// RESP  | status presented until accepted
module systolic_tile_sequencer #(
    parameter int DIM        = 8,
    parameter int ELEM_BYTES = 2,
    parameter int ADDR_W     = 64,
    parameter int LEN_W      = 34,
    parameter int K_W        = 20,
    parameter int TILE_W     = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [ADDR_W-1:0] cmd_act_addr,
    input  logic [ADDR_W-1:0] cmd_wgt_addr,
    input  logic [ADDR_W-1:0] cmd_out_addr,
    input  logic [K_W-1:0]    cmd_inner_dimension,
    input  logic [TILE_W-1:0] cmd_n_tiles,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic              resp_error,
    output logic [TILE_W-1:0] resp_tiles,
    output logic              act_req_valid,
    input  logic              act_req_ready,
    output logic [ADDR_W-1:0] act_req_addr,
    output logic [LEN_W-1:0]  act_req_len,
    output logic              wgt_req_valid,
    input  logic              wgt_req_ready,
    output logic [ADDR_W-1:0] wgt_req_addr,
    output logic [LEN_W-1:0]  wgt_req_len,
    output logic              out_req_valid,
    input  logic              out_req_ready,
    output logic [ADDR_W-1:0] out_req_addr,
    output logic [LEN_W-1:0]  out_req_len,
    input  logic              out_idle,
    output logic              sa_start_valid,
    input  logic              sa_start_ready,
    output logic [K_W-1:0]    sa_inner_dimension,
    input  logic              sa_done
);
    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_START, S_RUN, S_DRAIN, S_RESP} state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] act_addr_q, wgt_addr_q, out_addr_q;
    logic [K_W-1:0]    k_q;
    logic [TILE_W-1:0] n_tiles_q, t_q;
    logic              pend_act, pend_wgt, pend_out;
    logic [LEN_W-1:0]  len_a, len_o;
    logic              cmd_fire, cmd_bad, act_fire, wgt_fire, out_fire;
    logic              reqs_left, last_tile, next_tile, drain_done;

    assign len_a = LEN_W'(ELEM_BYTES * DIM) * LEN_W'(k_q);
    assign len_o = LEN_W'(ELEM_BYTES * DIM * DIM);

    assign cmd_ready  = (state == S_IDLE);
    assign cmd_fire   = cmd_valid && cmd_ready;
    assign cmd_bad    = (cmd_inner_dimension == '0) || (cmd_n_tiles == '0);
    assign act_fire   = act_req_valid && act_req_ready;
    assign wgt_fire   = wgt_req_valid && wgt_req_ready;
    assign out_fire   = out_req_valid && out_req_ready;
    assign reqs_left  = (pend_act && !act_fire) || (pend_wgt && !wgt_fire) || (pend_out && !out_fire);
    assign last_tile  = (t_q == n_tiles_q - TILE_W'(1));
    assign next_tile  = (state == S_RUN) && sa_done && !last_tile;
    assign drain_done = (state == S_DRAIN) && out_idle;

    assign act_req_valid      = pend_act;
    assign wgt_req_valid      = pend_wgt;
    assign out_req_valid      = pend_out;
    assign act_req_addr       = act_addr_q;
    assign wgt_req_addr       = wgt_addr_q;
    assign out_req_addr       = out_addr_q;
    assign act_req_len        = len_a;
    assign wgt_req_len        = len_a;
    assign out_req_len        = len_o;
    assign sa_start_valid     = (state == S_START);
    assign sa_inner_dimension = k_q;
    assign resp_valid         = (state == S_RESP);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE:  if (cmd_fire) state_nxt = cmd_bad ? S_RESP : S_ISSUE;
            S_ISSUE: if (!reqs_left) state_nxt = S_START;
            S_START: if (sa_start_ready) state_nxt = S_RUN;
            S_RUN:   if (sa_done) state_nxt = last_tile ? S_DRAIN : S_ISSUE;
            S_DRAIN: if (out_idle) state_nxt = S_RESP;
            S_RESP:  if (resp_ready) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // act/out addresses advance by one tile stride instead of multiplying by t
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            act_addr_q <= '0;
            wgt_addr_q <= '0;
            out_addr_q <= '0;
            k_q        <= '0;
            n_tiles_q  <= '0;
            t_q        <= '0;
            pend_act   <= 1'b0;
            pend_wgt   <= 1'b0;
            pend_out   <= 1'b0;
            resp_error <= 1'b0;
            resp_tiles <= '0;
        end else begin
            if (cmd_fire) begin
                act_addr_q <= cmd_act_addr;
                wgt_addr_q <= cmd_wgt_addr;
                out_addr_q <= cmd_out_addr;
                k_q        <= cmd_inner_dimension;
                n_tiles_q  <= cmd_n_tiles;
                t_q        <= '0;
                pend_act   <= !cmd_bad;
                pend_wgt   <= !cmd_bad;
                pend_out   <= !cmd_bad;
                resp_error <= cmd_bad;
                resp_tiles <= '0;
            end else if (next_tile) begin
                t_q        <= t_q + TILE_W'(1);
                act_addr_q <= act_addr_q + ADDR_W'(len_a);
                out_addr_q <= out_addr_q + ADDR_W'(len_o);
                pend_act   <= 1'b1;
                pend_wgt   <= 1'b1;
                pend_out   <= 1'b1;
            end else begin
                if (act_fire) pend_act <= 1'b0;
                if (wgt_fire) pend_wgt <= 1'b0;
                if (out_fire) pend_out <= 1'b0;
            end
            if (drain_done) resp_tiles <= n_tiles_q;
        end
    end
endmodule

// File: tb/tb_systolic_tile_sequencer.sv
// Bench for systolic_tile_sequencer: scoreboard of expected requests/responses,
// a simple array model, and directed scenarios in one initial block.
module tb_systolic_tile_sequencer;
    localparam int ADDR_W = 64;
    localparam int LEN_W  = 34;
    localparam int K_W    = 20;
    localparam int TILE_W = 16;

    logic              clock = 1'b0;
    logic              reset;
    logic              cmd_valid, cmd_ready;
    logic [ADDR_W-1:0] cmd_act_addr, cmd_wgt_addr, cmd_out_addr;
    logic [K_W-1:0]    cmd_inner_dimension;
    logic [TILE_W-1:0] cmd_n_tiles;
    logic              resp_valid, resp_ready, resp_error;
    logic [TILE_W-1:0] resp_tiles;
    logic              act_req_valid, act_req_ready, wgt_req_valid, wgt_req_ready;
    logic              out_req_valid, out_req_ready;
    logic [ADDR_W-1:0] act_req_addr, wgt_req_addr, out_req_addr;
    logic [LEN_W-1:0]  act_req_len, wgt_req_len, out_req_len;
    logic              out_idle, sa_start_valid, sa_start_ready, sa_done;
    logic [K_W-1:0]    sa_inner_dimension;

    systolic_tile_sequencer #(
        .DIM(8), .ELEM_BYTES(2), .ADDR_W(ADDR_W), .LEN_W(LEN_W), .K_W(K_W), .TILE_W(TILE_W)
    ) dut (
        .clock(clock), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_act_addr(cmd_act_addr), .cmd_wgt_addr(cmd_wgt_addr), .cmd_out_addr(cmd_out_addr),
        .cmd_inner_dimension(cmd_inner_dimension), .cmd_n_tiles(cmd_n_tiles),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_error(resp_error),
        .resp_tiles(resp_tiles),
        .act_req_valid(act_req_valid), .act_req_ready(act_req_ready),
        .act_req_addr(act_req_addr), .act_req_len(act_req_len),
        .wgt_req_valid(wgt_req_valid), .wgt_req_ready(wgt_req_ready),
        .wgt_req_addr(wgt_req_addr), .wgt_req_len(wgt_req_len),
        .out_req_valid(out_req_valid), .out_req_ready(out_req_ready),
        .out_req_addr(out_req_addr), .out_req_len(out_req_len),
        .out_idle(out_idle),
        .sa_start_valid(sa_start_valid), .sa_start_ready(sa_start_ready),
        .sa_inner_dimension(sa_inner_dimension), .sa_done(sa_done)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [63:0] addr;
        logic [33:0] len;
    } req_t;

    req_t        act_q[$], wgt_q[$], out_q[$];
    logic [16:0] resp_q[$];
    int          checks = 0, failures = 0;
    int          starts = 0, dones = 0, done_delay = 20;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string pfx);
        chk({pfx, "_act_valid"}, act_req_valid, 1'b0);
        chk({pfx, "_wgt_valid"}, wgt_req_valid, 1'b0);
        chk({pfx, "_out_valid"}, out_req_valid, 1'b0);
        chk({pfx, "_start_valid"}, sa_start_valid, 1'b0);
        chk({pfx, "_resp_valid"}, resp_valid, 1'b0);
        chk({pfx, "_resp_error"}, resp_error, 1'b0);
        chk({pfx, "_resp_tiles"}, resp_tiles, 16'd0);
        chk({pfx, "_sa_k"}, sa_inner_dimension, 20'd0);
        chk({pfx, "_act_addr"}, act_req_addr, 64'd0);
        chk({pfx, "_out_addr"}, out_req_addr, 64'd0);
    endtask

    task automatic send_cmd(input logic [63:0] a, input logic [63:0] w, input logic [63:0] o,
                            input int k, input int n);
        logic [33:0] la;
        bit          ok;
        la = 34'(16 * k);
        if (k == 0 || n == 0) begin
            resp_q.push_back({1'b1, 16'd0});
        end else begin
            for (int t = 0; t < n; t++) begin
                act_q.push_back('{addr: a + 64'(t) * 64'(la), len: la});
                wgt_q.push_back('{addr: w, len: la});
                out_q.push_back('{addr: o + 64'(t) * 64'd128, len: 34'd128});
            end
            resp_q.push_back({1'b0, 16'(n)});
        end
        @(posedge clock); #1;
        cmd_act_addr        = a;
        cmd_wgt_addr        = w;
        cmd_out_addr        = o;
        cmd_inner_dimension = K_W'(k);
        cmd_n_tiles         = TILE_W'(n);
        cmd_valid           = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clock);
            ok = cmd_ready;
        end
        if (!ok) chk("cmd_accept_timeout", cmd_ready, 1'b1);
        @(posedge clock); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_empty(input int budget);
        int i = 0;
        while ((resp_q.size() + act_q.size() + wgt_q.size() + out_q.size()) != 0 && i < budget) begin
            @(negedge clock);
            i++;
        end
        if (resp_q.size() != 0) chk("resp_timeout", resp_q.size(), 0);
        if (act_q.size() + wgt_q.size() + out_q.size() != 0)
            chk("req_timeout", act_q.size() + wgt_q.size() + out_q.size(), 0);
        @(posedge clock); #1;
    endtask

    // array model: busy for done_delay cycles after each start, then a one-cycle done pulse
    initial begin : array_model
        bit fired;
        int cnt;
        bit busy;
        sa_done = 1'b0;
        sa_start_ready = 1'b1;
        busy = 1'b0;
        cnt = 0;
        forever begin
            @(negedge clock);
            fired = !reset && sa_start_valid && sa_start_ready;
            if (fired) starts++;
            @(posedge clock); #1;
            sa_done = 1'b0;
            if (reset) begin
                busy = 1'b0;
                sa_start_ready = 1'b1;
            end else if (fired) begin
                busy = 1'b1;
                sa_start_ready = 1'b0;
                cnt = done_delay;
            end else if (busy) begin
                cnt--;
                if (cnt <= 0) begin
                    sa_done = 1'b1;
                    dones++;
                    busy = 1'b0;
                    sa_start_ready = 1'b1;
                end
            end
        end
    end

    // scoreboard pops on every fire; also checks valid/payload hold while stalled
    initial begin : monitor
        req_t        e;
        logic [16:0] r;
        logic [3:0]  pv, pr, cv, cr;
        logic [63:0] pa[3], ca[3];
        logic [33:0] pl[3], cl[3];
        string       nm[4];
        nm = '{"act", "wgt", "out", "start"};
        pv = '0;
        pr = '0;
        forever begin
            @(negedge clock);
            if (reset) begin
                pv = '0;
                continue;
            end
            cv = {sa_start_valid, out_req_valid, wgt_req_valid, act_req_valid};
            cr = {sa_start_ready, out_req_ready, wgt_req_ready, act_req_ready};
            ca = '{act_req_addr, wgt_req_addr, out_req_addr};
            cl = '{act_req_len, wgt_req_len, out_req_len};
            for (int i = 0; i < 4; i++) begin
                if (pv[i] && !pr[i]) begin
                    chk($sformatf("%s_hold_valid", nm[i]), cv[i], 1'b1);
                    if (i < 3) begin
                        chk($sformatf("%s_hold_addr", nm[i]), ca[i], pa[i]);
                        chk($sformatf("%s_hold_len", nm[i]), cl[i], pl[i]);
                    end
                end
            end
            if (act_req_valid && act_req_ready) begin
                if (act_q.size() == 0) chk("act_unexpected", act_req_valid, 1'b0);
                else begin
                    e = act_q.pop_front();
                    chk("act_addr", act_req_addr, e.addr);
                    chk("act_len", act_req_len, e.len);
                end
            end
            if (wgt_req_valid && wgt_req_ready) begin
                if (wgt_q.size() == 0) chk("wgt_unexpected", wgt_req_valid, 1'b0);
                else begin
                    e = wgt_q.pop_front();
                    chk("wgt_addr", wgt_req_addr, e.addr);
                    chk("wgt_len", wgt_req_len, e.len);
                end
            end
            if (out_req_valid && out_req_ready) begin
                if (out_q.size() == 0) chk("out_unexpected", out_req_valid, 1'b0);
                else begin
                    e = out_q.pop_front();
                    chk("out_addr", out_req_addr, e.addr);
                    chk("out_len", out_req_len, e.len);
                end
            end
            if (resp_valid && resp_ready) begin
                if (resp_q.size() == 0) chk("resp_unexpected", resp_valid, 1'b0);
                else begin
                    r = resp_q.pop_front();
                    chk("resp_error", resp_error, r[16]);
                    chk("resp_tiles", resp_tiles, r[15:0]);
                end
            end
            pv = cv;
            pr = cr;
            pa = ca;
            pl = cl;
        end
    end

    initial begin : stimulus
        int s0, d0, i;
        reset = 1'b1;
        cmd_valid = 1'b0;
        cmd_act_addr = '0;
        cmd_wgt_addr = '0;
        cmd_out_addr = '0;
        cmd_inner_dimension = '0;
        cmd_n_tiles = '0;
        act_req_ready = 1'b1;
        wgt_req_ready = 1'b1;
        out_req_ready = 1'b1;
        resp_ready = 1'b1;
        out_idle = 1'b1;

        @(negedge clock);
        chk_reset_outputs("por");
        @(posedge clock); #1;
        reset = 1'b0;
        @(negedge clock);
        chk("por_cmd_ready", cmd_ready, 1'b1);

        // single tile, K=16
        s0 = starts;
        send_cmd(64'h2000, 64'h3000, 64'h4000, 16, 1);
        @(negedge clock);
        chk("t1_act_len", act_req_len, 34'd256);
        chk("t1_wgt_len", wgt_req_len, 34'd256);
        chk("t1_out_len", out_req_len, 34'd128);
        chk("t1_sa_k", sa_inner_dimension, 20'd16);
        wait_empty(500);
        chk("t1_starts", starts - s0, 1);

        // three tiles, K=4
        s0 = starts;
        send_cmd(64'h1000, 64'h5000, 64'h8000, 4, 3);
        wait_empty(1000);
        chk("t2_starts", starts - s0, 3);

        // staggered readies
        act_req_ready = 1'b0;
        wgt_req_ready = 1'b0;
        out_req_ready = 1'b0;
        send_cmd(64'hA000, 64'hB000, 64'hC000, 2, 1);
        for (int cyc = 1; cyc <= 10; cyc++) begin
            @(posedge clock); #1;
            wgt_req_ready = (cyc == 1);
            act_req_ready = (cyc == 5);
            out_req_ready = (cyc == 9);
            @(negedge clock);
            chk($sformatf("stg_wgt_valid_c%0d", cyc), wgt_req_valid, cyc <= 1);
            chk($sformatf("stg_act_valid_c%0d", cyc), act_req_valid, cyc <= 5);
            chk($sformatf("stg_out_valid_c%0d", cyc), out_req_valid, cyc <= 9);
            chk($sformatf("stg_start_valid_c%0d", cyc), sa_start_valid, cyc >= 10);
        end
        act_req_ready = 1'b1;
        wgt_req_ready = 1'b1;
        out_req_ready = 1'b1;
        wait_empty(500);

        // error commands: K=0, then n_tiles=0
        send_cmd(64'h100, 64'h200, 64'h300, 0, 2);
        @(negedge clock);
        chk("errk_resp_valid", resp_valid, 1'b1);
        chk("errk_resp_error", resp_error, 1'b1);
        chk("errk_resp_tiles", resp_tiles, 16'd0);
        chk("errk_req_valids", {act_req_valid, wgt_req_valid, out_req_valid, sa_start_valid}, 4'b0);
        wait_empty(50);
        send_cmd(64'h100, 64'h200, 64'h300, 4, 0);
        @(negedge clock);
        chk("errn_resp_valid", resp_valid, 1'b1);
        chk("errn_resp_error", resp_error, 1'b1);
        chk("errn_resp_tiles", resp_tiles, 16'd0);
        chk("errn_req_valids", {act_req_valid, wgt_req_valid, out_req_valid, sa_start_valid}, 4'b0);
        wait_empty(50);

        // drain stall and response backpressure
        done_delay = 5;
        out_idle = 1'b0;
        resp_ready = 1'b0;
        d0 = dones;
        send_cmd(64'h4_0000, 64'h5_0000, 64'h6_0000, 2, 1);
        i = 0;
        while (dones == d0 && i < 200) begin
            @(negedge clock);
            i++;
        end
        chk("drain_done_seen", dones - d0, 1);
        for (int c = 0; c < 10; c++) begin
            @(posedge clock); #1;
            @(negedge clock);
            chk($sformatf("drain_no_resp_c%0d", c), resp_valid, 1'b0);
        end
        @(posedge clock); #1;
        out_idle = 1'b1;
        @(negedge clock);
        chk("drain_resp_not_early", resp_valid, 1'b0);
        @(negedge clock);
        chk("drain_resp_valid", resp_valid, 1'b1);
        for (int c = 0; c < 5; c++) begin
            @(negedge clock);
            chk($sformatf("bp_resp_valid_c%0d", c), resp_valid, 1'b1);
            chk($sformatf("bp_resp_error_c%0d", c), resp_error, 1'b0);
            chk($sformatf("bp_resp_tiles_c%0d", c), resp_tiles, 16'd1);
            chk($sformatf("bp_cmd_ready_c%0d", c), cmd_ready, 1'b0);
        end
        @(posedge clock); #1;
        resp_ready = 1'b1;
        wait_empty(50);
        @(negedge clock);
        chk("bp_cmd_ready_after", cmd_ready, 1'b1);
        done_delay = 20;

        // reset during RUN of tile 2 of 3
        s0 = starts;
        send_cmd(64'h1_0000, 64'h2_0000, 64'h3_0000, 8, 3);
        i = 0;
        while (starts - s0 < 2 && i < 500) begin
            @(negedge clock);
            i++;
        end
        chk("rst_reached_tile2", starts - s0, 2);
        repeat (3) @(negedge clock);
        #2 reset = 1'b1;
        #1 chk_reset_outputs("midrst");
        act_q.delete();
        wgt_q.delete();
        out_q.delete();
        resp_q.delete();
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        chk("midrst_cmd_ready", cmd_ready, 1'b1);
        s0 = starts;
        send_cmd(64'h7_0000, 64'h7_8000, 64'h9_0000, 3, 2);
        wait_empty(1000);
        chk("post_rst_starts", starts - s0, 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
